// File: rtl/uart_boot_loader.sv
// UART program loader: receives a big-endian word image over 8N1 serial, writes it
// into instruction memory and holds the CPU in reset until the image is complete.
module uart_boot_loader #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned MEM_WORDS    = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        uart_rx,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        cpu_reset,
   output logic        loading,
   output logic        done,
   output logic        error
);

   localparam int unsigned TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [16:0]   MAX_WORDS = 17'(MEM_WORDS);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {LD_HDR_HI, LD_HDR_LO, LD_WORD, LD_RELEASE,
                             LD_DONE, LD_ERROR} ld_state_t;

   logic rx_meta, rx_sync;

   rx_state_t     rx_state, rx_state_nxt;
   logic [TW-1:0] rx_timer, rx_timer_nxt;
   logic [2:0]    rx_bit, rx_bit_nxt;
   logic [7:0]    rx_shift, rx_shift_nxt;
   logic          byte_valid, byte_valid_nxt;
   logic          frame_err, frame_err_nxt;

   ld_state_t   ld_state, ld_state_nxt;
   logic [15:0] count, count_nxt;
   logic [15:0] word_idx, word_idx_nxt;
   logic [1:0]  byte_in_word, byte_in_word_nxt;
   logic [23:0] word_buf, word_buf_nxt;
   logic        mem_we_nxt;
   logic [31:0] mem_addr_nxt, mem_wdata_nxt;
   logic        cpu_reset_nxt, loading_nxt, done_nxt, error_nxt;
   logic [15:0] hdr_count;

   assign hdr_count = {count[15:8], rx_shift};

   // Two-flop synchronizer; idles high so reset never looks like a start bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
      end
   end

   // Receiver registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         rx_timer   <= '0;
         rx_bit     <= '0;
         rx_shift   <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_state   <= rx_state_nxt;
         rx_timer   <= rx_timer_nxt;
         rx_bit     <= rx_bit_nxt;
         rx_shift   <= rx_shift_nxt;
         byte_valid <= byte_valid_nxt;
         frame_err  <= frame_err_nxt;
      end
   end

   // Receiver next state: start bit is re-checked at mid-bit to reject glitches
   always_comb begin
      rx_state_nxt   = rx_state;
      rx_timer_nxt   = rx_timer;
      rx_bit_nxt     = rx_bit;
      rx_shift_nxt   = rx_shift;
      byte_valid_nxt = 1'b0;
      frame_err_nxt  = 1'b0;
      case (rx_state)
         RX_IDLE: begin
            rx_timer_nxt = '0;
            if (!rx_sync) rx_state_nxt = RX_START;
         end
         RX_START: begin
            if (rx_timer == HALF_LAST) begin
               rx_timer_nxt = '0;
               rx_bit_nxt   = '0;
               rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            end else begin
               rx_timer_nxt = rx_timer + TW'(1);
            end
         end
         RX_DATA: begin
            if (rx_timer == BIT_LAST) begin
               rx_timer_nxt = '0;
               rx_shift_nxt = {rx_sync, rx_shift[7:1]};
               rx_bit_nxt   = rx_bit + 3'd1;
               if (rx_bit == 3'd7) rx_state_nxt = RX_STOP;
            end else begin
               rx_timer_nxt = rx_timer + TW'(1);
            end
         end
         RX_STOP: begin
            if (rx_timer == BIT_LAST) begin
               rx_timer_nxt   = '0;
               byte_valid_nxt = rx_sync;
               frame_err_nxt  = !rx_sync;
               rx_state_nxt   = RX_IDLE;
            end else begin
               rx_timer_nxt = rx_timer + TW'(1);
            end
         end
         default: rx_state_nxt = RX_IDLE;
      endcase
   end

   // Loader registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ld_state     <= LD_HDR_HI;
         count        <= '0;
         word_idx     <= '0;
         byte_in_word <= '0;
         word_buf     <= '0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         cpu_reset    <= 1'b1;
         loading      <= 1'b1;
         done         <= 1'b0;
         error        <= 1'b0;
      end else begin
         ld_state     <= ld_state_nxt;
         count        <= count_nxt;
         word_idx     <= word_idx_nxt;
         byte_in_word <= byte_in_word_nxt;
         word_buf     <= word_buf_nxt;
         mem_we       <= mem_we_nxt;
         mem_addr     <= mem_addr_nxt;
         mem_wdata    <= mem_wdata_nxt;
         cpu_reset    <= cpu_reset_nxt;
         loading      <= loading_nxt;
         done         <= done_nxt;
         error        <= error_nxt;
      end
   end

   // Loader next state; release is decided in the cycle the last write is on the bus
   always_comb begin
      ld_state_nxt     = ld_state;
      count_nxt        = count;
      word_idx_nxt     = word_idx;
      byte_in_word_nxt = byte_in_word;
      word_buf_nxt     = word_buf;
      mem_we_nxt       = 1'b0;
      mem_addr_nxt     = mem_addr;
      mem_wdata_nxt    = mem_wdata;
      cpu_reset_nxt    = cpu_reset;
      loading_nxt      = loading;
      done_nxt         = done;
      error_nxt        = error;
      case (ld_state)
         LD_HDR_HI: begin
            if (frame_err) begin
               ld_state_nxt = LD_ERROR;
            end else if (byte_valid) begin
               count_nxt    = {rx_shift, count[7:0]};
               ld_state_nxt = LD_HDR_LO;
            end
         end
         LD_HDR_LO: begin
            if (frame_err) begin
               ld_state_nxt = LD_ERROR;
            end else if (byte_valid) begin
               count_nxt        = hdr_count;
               word_idx_nxt     = '0;
               byte_in_word_nxt = '0;
               if (hdr_count == 16'd0)                 ld_state_nxt = LD_RELEASE;
               else if ({1'b0, hdr_count} > MAX_WORDS) ld_state_nxt = LD_ERROR;
               else                                    ld_state_nxt = LD_WORD;
            end
         end
         LD_WORD: begin
            if (mem_we && word_idx == count) begin
               ld_state_nxt = LD_RELEASE;
            end else if (frame_err) begin
               ld_state_nxt = LD_ERROR;
            end else if (byte_valid) begin
               word_buf_nxt     = {word_buf[15:0], rx_shift};
               byte_in_word_nxt = byte_in_word + 2'd1;
               if (byte_in_word == 2'd3) begin
                  mem_we_nxt    = 1'b1;
                  mem_addr_nxt  = {14'd0, word_idx, 2'b00};
                  mem_wdata_nxt = {word_buf, rx_shift};
                  word_idx_nxt  = word_idx + 16'd1;
               end
            end
         end
         LD_RELEASE: begin
            cpu_reset_nxt = 1'b0;
            done_nxt      = 1'b1;
            loading_nxt   = 1'b0;
            ld_state_nxt  = LD_DONE;
         end
         LD_DONE:  ld_state_nxt = LD_DONE;
         LD_ERROR: ld_state_nxt = LD_ERROR;
         default:  ld_state_nxt = LD_ERROR;
      endcase
      if (ld_state_nxt == LD_ERROR) begin
         error_nxt   = 1'b1;
         loading_nxt = 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: serial byte images with hand-computed writes.
module tb_uart_boot_loader;

   localparam int unsigned CPB = 4;
   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        uart_rx = 1'b1;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        cpu_reset;
   logic        loading;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int fall_cyc = -1;
   logic cpu_reset_d = 1'b1;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          we_cyc_q[$];

   uart_boot_loader #(.CLKS_PER_BIT(CPB), .MEM_WORDS(16)) dut (
      .clk(clk), .reset(reset), .uart_rx(uart_rx), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
      .loading(loading), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Write and release monitor, sampled on the falling edge
   always @(negedge clk) begin
      cyc++;
      if (mem_we === 1'b1) begin
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         we_cyc_q.push_back(cyc);
      end
      if (cpu_reset_d === 1'b1 && cpu_reset === 1'b0) fall_cyc = cyc;
      cpu_reset_d = cpu_reset;
   end

   task automatic send_bit(input logic b);
      #1 uart_rx = b;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      send_bit(1'b1);
      send_bit(1'b1);
   endtask

   task automatic send_seq(input bytes_t bs);
      foreach (bs[i]) send_frame(bs[i], 1'b1);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL %s_timeout: done=%b required 1 within 400 cycles", name, done);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_mem_we: got %b need 0", mem_we); end
      checks++; if (mem_addr !== 32'h0)  begin errors++; $display("FAIL rst_mem_addr: got %h need 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata: got %h need 0", mem_wdata); end
      checks++; if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL rst_cpu_reset: got %b need 1", cpu_reset); end
      checks++; if (loading !== 1'b1)    begin errors++; $display("FAIL rst_loading: got %b need 1", loading); end
      checks++; if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b need 0", done); end
      checks++; if (error !== 1'b0)      begin errors++; $display("FAIL rst_error: got %b need 0", error); end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_glitch();
      int base;
      base = wr_addr_q.size();
      @(posedge clk);
      #1 uart_rx = 1'b0;
      @(posedge clk);
      #1 uart_rx = 1'b1;
      repeat (40) @(negedge clk);
      checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL glitch_writes: got %0d need 0", wr_addr_q.size() - base); end
      checks++; if (loading !== 1'b1 || error !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL glitch_flags: loading=%b error=%b done=%b need 1 0 0", loading, error, done);
      end
   endtask

   task automatic test_load();
      int base;
      bytes_t b;
      base = wr_addr_q.size();
      b = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
      send_seq(b);
      wait_done("load");
      checks++; if (wr_addr_q.size() - base != 2) begin errors++; $display("FAIL load_count: got %0d writes need 2", wr_addr_q.size() - base); end
      if (wr_addr_q.size() - base == 2) begin
         checks++; if (wr_addr_q[base] !== 32'h0)          begin errors++; $display("FAIL load_addr0: got %h need 00000000", wr_addr_q[base]); end
         checks++; if (wr_data_q[base] !== 32'h20080005)   begin errors++; $display("FAIL load_data0: got %h need 20080005", wr_data_q[base]); end
         checks++; if (wr_addr_q[base+1] !== 32'h4)        begin errors++; $display("FAIL load_addr1: got %h need 00000004", wr_addr_q[base+1]); end
         checks++; if (wr_data_q[base+1] !== 32'h0000000C) begin errors++; $display("FAIL load_data1: got %h need 0000000c", wr_data_q[base+1]); end
         checks++; if (fall_cyc - we_cyc_q[base+1] != 2)   begin errors++; $display("FAIL load_release_latency: got %0d cycles need 2", fall_cyc - we_cyc_q[base+1]); end
      end
      checks++; if (cpu_reset !== 1'b0 || done !== 1'b1 || error !== 1'b0 || loading !== 1'b0) begin
         errors++; $display("FAIL load_flags: cpu_reset=%b done=%b error=%b loading=%b need 0 1 0 0", cpu_reset, done, error, loading);
      end
      checks++; if (mem_addr !== 32'h4 || mem_wdata !== 32'h0000000C) begin
         errors++; $display("FAIL load_hold: addr=%h data=%h need 00000004 0000000c", mem_addr, mem_wdata);
      end
   endtask

   task automatic test_after_done();
      int base;
      bytes_t b;
      base = wr_addr_q.size();
      b = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
      send_seq(b);
      send_frame(8'hA5, 1'b0);
      repeat (10) @(negedge clk);
      checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL after_done_writes: got %0d need 0", wr_addr_q.size() - base); end
      checks++; if (done !== 1'b1 || cpu_reset !== 1'b0 || error !== 1'b0) begin
         errors++; $display("FAIL after_done_flags: done=%b cpu_reset=%b error=%b need 1 0 0", done, cpu_reset, error);
      end
   endtask

   task automatic test_empty();
      int base;
      bytes_t b;
      apply_reset();
      base = wr_addr_q.size();
      b = '{8'h00, 8'h00};
      send_seq(b);
      wait_done("empty");
      checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL empty_writes: got %0d need 0", wr_addr_q.size() - base); end
      checks++; if (cpu_reset !== 1'b0 || error !== 1'b0 || loading !== 1'b0) begin
         errors++; $display("FAIL empty_flags: cpu_reset=%b error=%b loading=%b need 0 0 0", cpu_reset, error, loading);
      end
   endtask

   task automatic test_oversize();
      int base;
      bytes_t b;
      apply_reset();
      base = wr_addr_q.size();
      b = '{8'h00, 8'h11, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_seq(b);
      repeat (10) @(negedge clk);
      checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || loading !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL oversize_flags: error=%b cpu_reset=%b loading=%b done=%b need 1 1 0 0", error, cpu_reset, loading, done);
      end
      checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL oversize_writes: got %0d need 0", wr_addr_q.size() - base); end
   endtask

   task automatic test_framing();
      int base;
      bytes_t b;
      apply_reset();
      base = wr_addr_q.size();
      b = '{8'h00, 8'h02, 8'h20, 8'h08};
      send_seq(b);
      send_frame(8'h00, 1'b0);
      repeat (8) @(negedge clk);
      b = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
      send_seq(b);
      repeat (10) @(negedge clk);
      checks++; if (error !== 1'b1 || cpu_reset !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL framing_flags: error=%b cpu_reset=%b done=%b need 1 1 0", error, cpu_reset, done);
      end
      checks++; if (wr_addr_q.size() != base) begin errors++; $display("FAIL framing_writes: got %0d need 0", wr_addr_q.size() - base); end
   endtask

   task automatic test_reset_midload();
      int base;
      bytes_t b;
      apply_reset();
      base = wr_addr_q.size();
      b = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_seq(b);
      checks++; if (wr_addr_q.size() - base != 1) begin errors++; $display("FAIL midload_first_count: got %0d need 1", wr_addr_q.size() - base); end
      if (wr_addr_q.size() - base == 1) begin
         checks++; if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'h11223344) begin
            errors++; $display("FAIL midload_first_word: addr=%h data=%h need 00000000 11223344", wr_addr_q[base], wr_data_q[base]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         errors++; $display("FAIL midload_rst_bus: we=%b addr=%h data=%h need 0 0 0", mem_we, mem_addr, mem_wdata);
      end
      checks++; if (cpu_reset !== 1'b1 || loading !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
         errors++; $display("FAIL midload_rst_flags: cpu_reset=%b loading=%b done=%b error=%b need 1 1 0 0", cpu_reset, loading, done, error);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      base = wr_addr_q.size();
      b = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
      send_seq(b);
      wait_done("reload");
      checks++; if (wr_addr_q.size() - base != 1) begin errors++; $display("FAIL reload_count: got %0d need 1", wr_addr_q.size() - base); end
      if (wr_addr_q.size() - base == 1) begin
         checks++; if (wr_addr_q[base] !== 32'h0 || wr_data_q[base] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL reload_word: addr=%h data=%h need 00000000 deadbeef", wr_addr_q[base], wr_data_q[base]);
         end
         checks++; if (fall_cyc - we_cyc_q[base] != 2) begin errors++; $display("FAIL reload_latency: got %0d need 2", fall_cyc - we_cyc_q[base]); end
      end
      checks++; if (cpu_reset !== 1'b0 || error !== 1'b0) begin
         errors++; $display("FAIL reload_flags: cpu_reset=%b error=%b need 0 0", cpu_reset, error);
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_load();
      test_after_done();
      test_empty();
      test_oversize();
      test_framing();
      test_reset_midload();
      test_after_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
